// File: rtl/bcd_scan_display.sv
// Display stage: captures packed 4-digit BCD and scans it onto a
// common-anode 7-segment display with optional leading-zero blanking.
module bcd_scan_display #(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd_in,
    input  logic        bcd_valid,
    output logic [3:0]  seg_anode,
    output logic [6:0]  seg_cathode,
    output logic [15:0] held_bcd
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [3:0]    nib;
    logic          blank;
    logic [6:0]    pat;
    logic [3:0]    an_next;
    logic [6:0]    cat_next;

    always_comb begin
        nib = held_bcd[{idx, 2'b00} +: 4];
        unique case (idx)
            2'd0: blank = 1'b0;
            2'd1: blank = (held_bcd[15:4] == 12'h000);
            2'd2: blank = (held_bcd[15:8] == 8'h00);
            2'd3: blank = (held_bcd[15:12] == 4'h0);
        endcase
        blank = blank & BLANK_LZ;
    end

    always_comb begin
        unique case (nib)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = 7'b0111111;
        endcase
    end

    always_comb begin
        an_next  = ~(4'b0001 << idx);
        cat_next = pat;
        if (blank) begin
            an_next  = 4'b1111;
            cat_next = 7'b1111111;
        end
    end

    // Outputs are registered from the pre-edge index and held value,
    // so they trail an index change or a capture by one cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            held_bcd    <= 16'h0000;
            cnt         <= '0;
            idx         <= 2'd0;
            seg_anode   <= 4'b1111;
            seg_cathode <= 7'b1111111;
        end else begin
            if (bcd_valid) begin
                held_bcd <= bcd_in;
            end
            if (cnt == TERM) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            seg_anode   <= an_next;
            seg_cathode <= cat_next;
        end
    end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Downstream display stage for the sequential-multiplier datapath. It captures the packed 4-digit BCD result when the binary-to-BCD converter pulses ready, and holds it until the next capture. It time-multiplexes the four digits onto a common-anode 7-segment display, with optional leading-zero blanking and a dash for illegal BCD nibbles. The block replaces the hand-written result register and generic segment driver at the top level.

## Interface
- REFRESH_DIV, 100000: clock cycles each digit is driven; must be ≥ 2.
- BLANK_LZ, 1: 1 enables leading-zero blanking; 0 shows all four digits.
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-low.
- bcd_in  input  16  packed BCD; [3:0] is units (digit 0), [15:12] is thousands (digit 3).
- bcd_valid  input  1  capture strobe; the ready pulse from the BCD converter.
- seg_anode  output  4  digit enables, active-low; bit k drives digit k, and bit 0 is the rightmost digit.
- seg_cathode  output  7  segments {g,f,e,d,c,b,a}, active-low.
- held_bcd  output  16  currently captured value, for observation and verification.

## Operation
- **Capture register (held_bcd):**
  - At each edge where rst=1 and bcd_valid=1: held_bcd ← bcd_in.
  - Otherwise it holds.
  - bcd_valid held high for several cycles recaptures every cycle.
- **Refresh counter:**
  - Runs 0..REFRESH_DIV-1 and wraps to 0.
  - At the terminal count, the digit index (2 bits) increments 0→1→2→3→0.
- **Digit decode (combinational on held_bcd and index), nibble → cathode pattern:**
  - 0 → 1000000
  - 1 → 1111001
  - 2 → 0100100
  - 3 → 0110000
  - 4 → 0011001
  - 5 → 0010010
  - 6 → 0000010
  - 7 → 1111000
  - 8 → 0000000
  - 9 → 0010000
  - 10..15 → 0111111 (dash)
- **Leading-zero blanking:**
  - With BLANK_LZ=1, digit k (k = 1..3) is blank when nibbles k..3 of held_bcd are all zero.
  - Digit 0 is never blanked, so value 0 displays "0".
  - A blank digit drives seg_anode=1111 and seg_cathode=1111111 for its whole dwell slot.
  - A non-blank digit drives seg_anode with only bit index low, plus its decoded pattern.
- **Output registers:** seg_anode and seg_cathode are registered from the decode of the current index and held_bcd, so there are no combinational output glitches.
- **Reset (rst=0 at an edge):**
  - held_bcd=0, counter=0, index=0.
  - seg_anode=1111, seg_cathode=1111111.
  - Reset mid-scan discards the capture and restarts the scan at digit 0.

## Timing
- Capture: bcd_valid high at edge N puts the new held_bcd value after edge N.
- Display latency: the outputs reflect the new value after edge N+1 if the scanned digit is affected. The scan is not restarted by a capture.
- Reset release: rst=1 at edge R gives seg_anode=1110 and a digit-0 pattern after edge R.
- Dwell: index changes exactly every REFRESH_DIV cycles; a full frame is 4·REFRESH_DIV cycles.
- Outputs follow an index change one cycle later. Each anode is therefore active for exactly REFRESH_DIV consecutive cycles, and never more than one anode bit is low.
- Capture coinciding with an index wrap: both take effect, and the new digit shows the new value one cycle later.
- bcd_valid asserted while rst=0 is ignored.

## Test plan
- **Reset:**
  - Drive rst=0 for 3 cycles → seg_anode=1111, seg_cathode=1111111, held_bcd=0000.
  - Release reset → next cycle seg_anode=1110, seg_cathode=1000000. Digits 1..3 stay blank with anode 1111 (BLANK_LZ=1).
- **Full scan (REFRESH_DIV=4):**
  - Pulse bcd_valid with bcd_in=16'h0225 (15×15).
  - Digit 0 shows 0010010 (5) and digit 1 shows 0100100 (2), each with its own anode low for exactly 4 cycles.
  - Digit 2 shows 0100100 with anode 1011.
  - Digit 3 is blank (1111/1111111).
- **Blanking off:**
  - Set BLANK_LZ=0 and bcd_in=16'h0000.
  - All four slots show 1000000, with anodes 1110, 1101, 1011, 0111 in order.
- **Illegal nibble:**
  - Set bcd_in=16'h0A03.
  - Digit 1 shows 1000000 (not blank, since a higher nibble is nonzero).
  - Digit 2 shows dash 0111111; digit 3 is blank.
- **Mid-scan update:**
  - While digit 0 is active showing 16'h0007, pulse bcd_valid with 16'h0009 at edge N.
  - held_bcd=0009 after N; seg_cathode=0010000 after N+1.
  - The index and dwell count are unchanged.
- **Reset mid-operation:**
  - While digit 2 is active with held_bcd=16'h0144, assert rst=0 for one edge.
  - Outputs go to 1111/1111111 and held_bcd=0.
  - After release the scan restarts at digit 0 showing 1000000.
